// File: rtl/bootrom_arbiter_if.sv
// bootrom_arbiter_if: requester, overlay and ROM-side signals of the boot ROM arbiter
interface bootrom_arbiter_if #(parameter int AW = 14, parameter int DW = 8);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          aux_req;
  logic [AW-1:0] aux_addr;
  logic          aux_ack;
  logic [DW-1:0] aux_rdata;
  logic          boot_disable;
  logic          boot_active;
  logic          rom_rd_n;
  logic [AW-1:0] rom_a;
  logic [DW-1:0] rom_d;
  modport master (
    output cpu_req, cpu_addr, aux_req, aux_addr, boot_disable, rom_d,
    input  cpu_ack, cpu_rdata, aux_ack, aux_rdata, boot_active, rom_rd_n, rom_a
  );
  modport slave (
    input  cpu_req, cpu_addr, aux_req, aux_addr, boot_disable, rom_d,
    output cpu_ack, cpu_rdata, aux_ack, aux_rdata, boot_active, rom_rd_n, rom_a
  );
endinterface

// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares the boot ROM between CPU and aux reader, owns the BIOS overlay; BOOTARB_ROUND_ROBIN_EN selects round-robin ties
module bootrom_arbiter #(
  parameter int            AW       = 14,
  parameter int            DW       = 8,
  parameter logic [DW-1:0] OPEN_BUS = 8'hFF
) (
  input logic               clk,
  input logic               rst,
  bootrom_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic          win_q, win_d;
  logic          byp_q, byp_d;
  logic          rom_rd_n_q;
  logic [AW-1:0] rom_a_q;
  logic [DW-1:0] cpu_rdata_q, aux_rdata_q;
  logic          boot_active_q;
  logic          any_req, grant;
`ifdef BOOTARB_ROUND_ROBIN_EN
  logic          last_q;
`endif
  assign any_req = bus.cpu_req | bus.aux_req;
  assign grant   = (state_q == IDLE) & any_req;
  // Winner selection (1 = aux), bypass decision and FSM next state
  always_comb begin
`ifdef BOOTARB_ROUND_ROBIN_EN
    win_d   = (bus.cpu_req & bus.aux_req) ? ~last_q : ~bus.cpu_req;
`else
    win_d   = ~bus.cpu_req;
`endif
    byp_d   = ~win_d & ~boot_active_q;
    state_d = (state_q == IDLE)  ? (any_req ? ISSUE : IDLE) :
              (state_q == ISSUE) ? WAIT :
              (state_q == WAIT)  ? DONE : IDLE;
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  // Grant latching, ROM strobe, data capture and sticky overlay disable
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q         <= 1'b0;
      byp_q         <= 1'b0;
      rom_rd_n_q    <= 1'b1;
      rom_a_q       <= '0;
      cpu_rdata_q   <= '0;
      aux_rdata_q   <= '0;
      boot_active_q <= 1'b1;
`ifdef BOOTARB_ROUND_ROBIN_EN
      last_q        <= 1'b0;
`endif
    end else begin
      boot_active_q <= boot_active_q & ~bus.boot_disable;
      if (grant) begin
        win_q <= win_d;
        byp_q <= byp_d;
`ifdef BOOTARB_ROUND_ROBIN_EN
        last_q <= win_d;
`endif
        if (!byp_d) begin
          rom_a_q    <= win_d ? bus.aux_addr : bus.cpu_addr;
          rom_rd_n_q <= 1'b0;
        end
      end
      if (state_q == ISSUE) rom_rd_n_q <= 1'b1;
      if (state_q == WAIT) begin
        if (win_q) aux_rdata_q <= bus.rom_d;
        else       cpu_rdata_q <= byp_q ? OPEN_BUS : bus.rom_d;
      end
    end
  end
  assign bus.cpu_ack     = (state_q == DONE) & ~win_q;
  assign bus.aux_ack     = (state_q == DONE) & win_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.aux_rdata   = aux_rdata_q;
  assign bus.boot_active = boot_active_q;
  assign bus.rom_rd_n    = rom_rd_n_q;
  assign bus.rom_a       = rom_a_q;
endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb_bootrom_arbiter: directed and randomized checks of bootrom_arbiter against a transaction-timing model
module tb_bootrom_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] rom_mem [16384];
  bootrom_arbiter_if bus ();
  bootrom_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // ROM: one-cycle registered read
  always @(posedge clk) if (!bus.rom_rd_n) bus.rom_d <= rom_mem[bus.rom_a];
  int         k = 0;
  logic       act = 1'b0;
  int         g = -10;
  int         free_at = 0;
  logic       mw, mbyp, m_ba, m_last;
  logic [13:0] ma;
  logic [7:0] m_cpu_rd, m_aux_rd;
  int         n_cpu_ack, n_aux_ack;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, k);
    end
  endtask
  function automatic logic pick_aux(input logic cr, input logic ar);
`ifdef BOOTARB_ROUND_ROBIN_EN
    if (cr && ar) return !m_last;
`endif
    return !cr;
  endfunction
  // One clock: drive inputs, advance the model across the edge, then check outputs
  task automatic step(input logic r, input logic cr, input logic [13:0] ca,
                      input logic ar, input logic [13:0] aa, input logic bd);
    rst = r;
    bus.cpu_req = cr; bus.cpu_addr = ca;
    bus.aux_req = ar; bus.aux_addr = aa;
    bus.boot_disable = bd;
    if (r) begin
      act = 1'b0; free_at = 0; m_cpu_rd = 8'h00; m_aux_rd = 8'h00; m_ba = 1'b1; m_last = 1'b0;
    end else begin
      if (k + 1 >= free_at && (cr || ar)) begin
        g = k + 1; act = 1'b1; free_at = g + 4;
        mw = pick_aux(cr, ar);
        mbyp = !mw && !m_ba;
        ma = mw ? aa : ca;
        m_last = mw;
      end
      if (act && k + 1 == g + 2) begin
        if (mw) m_aux_rd = rom_mem[ma];
        else    m_cpu_rd = mbyp ? 8'hFF : rom_mem[ma];
      end
      if (bd) m_ba = 1'b0;
    end
    @(posedge clk);
    k++;
    @(negedge clk);
    if (bus.cpu_ack) n_cpu_ack++;
    if (bus.aux_ack) n_aux_ack++;
    check("cpu_ack", bus.cpu_ack, act && k == g + 2 && !mw);
    check("aux_ack", bus.aux_ack, act && k == g + 2 && mw);
    check("rom_rd_n", bus.rom_rd_n, !(act && k == g && !mbyp));
    if (act && k == g && !mbyp) check("rom_a", bus.rom_a, ma);
    if (r) check("rom_a_rst", bus.rom_a, 0);
    check("cpu_rdata", bus.cpu_rdata, m_cpu_rd);
    check("aux_rdata", bus.aux_rdata, m_aux_rd);
    check("boot_active", bus.boot_active, m_ba);
  endtask
  task automatic rd(input logic aux, input logic [13:0] a, input logic bd);
    step(1'b0, !aux, a, aux, a, bd);
    step(1'b0, !aux, a, aux, a, 1'b0);
    step(1'b0, !aux, a, aux, a, 1'b0);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0);
  endtask
  initial begin
    logic       cr, ar, bd, r;
    logic [13:0] ca, aa;
    for (int i = 0; i < 16384; i++) rom_mem[i] = 8'($urandom);
    rom_mem[0] = 8'hF3;
    rom_mem[14'h3FFF] = 8'h5A;
    bus.rom_d = 8'h00;
    step(1'b1, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0);
    step(1'b1, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'h00);
    check("rst_boot_active", bus.boot_active, 1);
    rd(1'b0, 14'h0000, 1'b0);
    check("t1_cpu_rdata", bus.cpu_rdata, 8'hF3);
    idle();
    rd(1'b1, 14'h3FFF, 1'b0);
    check("t2_aux_rdata", bus.aux_rdata, 8'h5A);
    check("t2_cpu_keep", bus.cpu_rdata, 8'hF3);
    idle();
    n_cpu_ack = 0; n_aux_ack = 0;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 14'h0001, 1'b1, 14'h0002, 1'b0);
    idle();
`ifdef BOOTARB_ROUND_ROBIN_EN
    check("contend_cpu_acks", n_cpu_ack, 2);
    check("contend_aux_acks", n_aux_ack, 2);
`else
    check("contend_cpu_acks", n_cpu_ack, 4);
    check("contend_aux_acks", n_aux_ack, 0);
`endif
    rd(1'b0, 14'h0010, 1'b1);
    check("same_cycle_disable", bus.cpu_rdata, rom_mem[16]);
    check("disabled", bus.boot_active, 0);
    idle();
    rd(1'b0, 14'h0010, 1'b0);
    check("bypass_rdata", bus.cpu_rdata, 8'hFF);
    idle();
    rd(1'b1, 14'h0010, 1'b0);
    check("aux_after_disable", bus.aux_rdata, rom_mem[16]);
    idle();
    step(1'b0, 1'b1, 14'h0000, 1'b0, 14'h0, 1'b0);
    step(1'b0, 1'b1, 14'h0000, 1'b0, 14'h0, 1'b0);
    step(1'b1, 1'b1, 14'h0000, 1'b0, 14'h0, 1'b0);
    check("wait_rst_ack", bus.cpu_ack, 0);
    check("wait_rst_rd_n", bus.rom_rd_n, 1);
    check("wait_rst_rdata", bus.cpu_rdata, 8'h00);
    check("wait_rst_ba", bus.boot_active, 1);
    rd(1'b0, 14'h0000, 1'b0);
    check("post_rst_rdata", bus.cpu_rdata, 8'hF3);
    idle();
    cr = 1'b0; ar = 1'b0; ca = '0; aa = '0;
    for (int i = 0; i < 3000; i++) begin
      if (act && k == g + 2 && !mw && ($urandom % 2 == 0)) cr = 1'b0;
      else if (!cr && ($urandom % 3 == 0)) begin cr = 1'b1; ca = 14'($urandom); end
      if (act && k == g + 2 && mw && ($urandom % 2 == 0)) ar = 1'b0;
      else if (!ar && ($urandom % 3 == 0)) begin ar = 1'b1; aa = 14'($urandom); end
      bd = ($urandom % 150 == 0);
      r  = ($urandom % 300 == 0);
      step(r, cr, ca, ar, aa, bd);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bootrom_arbiter.md
Name: bootrom_arbiter

Overview:
- Sequences and shares the single-port synchronous boot ROM (14-bit address, 8-bit data, active-low read enable, 1-cycle registered read) between two requesters.
- Requesters: the Z80 CPU path and an auxiliary reader (loader/checksum engine).
- Owns the BIOS overlay state: once the boot ROM is disabled, CPU reads return open-bus data without touching the ROM.
- Sits between the CPU memory decoder / aux engine and the ROM instance.

Parameters:
- AW, 14, ROM address width.
- DW, 8, ROM data width.
- OPEN_BUS, 8'hFF, data returned to the CPU while the overlay is disabled.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU read request, level; held until cpu_ack.
- cpu_addr  in  AW  CPU read address; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle pulse; cpu_rdata valid in that cycle.
- cpu_rdata  out  DW  CPU read data; holds until the next cpu_ack.
- aux_req  in  1  aux read request, level; held until aux_ack.
- aux_addr  in  AW  aux read address.
- aux_ack  out  1  one-cycle pulse.
- aux_rdata  out  DW  aux read data; holds until the next aux_ack.
- boot_disable  in  1  pulse; permanently unmaps the boot ROM from the CPU until reset.
- boot_active  out  1  1 = boot ROM is visible to the CPU.
- rom_rd_n  out  1  ROM read enable, active low, registered.
- rom_a  out  AW  ROM address, registered.
- rom_d  in  DW  ROM data, valid the cycle after the edge that samples rom_rd_n = 0.

Behaviour:
- Reset values:
  - state = IDLE
  - rom_rd_n = 1, rom_a = 0
  - cpu_ack = aux_ack = 0
  - cpu_rdata = aux_rdata = 0
  - boot_active = 1
  - arbitration pointer = CPU
- Reset applied mid-transaction discards the in-flight read; no ack is issued.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE, cycle N:
  - If any request is present, pick a winner.
  - Latch the winner id and a bypass flag (bypass = winner is CPU and boot_active = 0).
  - If not bypass: rom_a <= winner addr and rom_rd_n <= 0.
  - Go to ISSUE.
- ISSUE, N+1: ROM samples the address; rom_rd_n <= 1; go to WAIT.
- WAIT, N+2: rom_d is valid; capture it into the winner's rdata register (OPEN_BUS if bypass); go to DONE.
- DONE, N+3: winner's ack = 1 for exactly one cycle; go to IDLE.
- Timing:
  - Latency is 3 cycles from the request being sampled in IDLE to its ack.
  - A held request is re-granted in the IDLE cycle after DONE, so maximum throughput is 1 read per 4 cycles.
- Bypass reads:
  - Same timing as a ROM read.
  - rom_rd_n stays 1 for the whole transaction.
  - cpu_rdata = OPEN_BUS.
- Arbitration (default): fixed priority, CPU over aux. Aux can starve while cpu_req is continuously high.
- Requests are decoded only in IDLE; a request deasserted before its ack is a protocol violation (undefined, no recovery required).
- Address changes while a request is granted are ignored; the address is latched in IDLE.
- boot_disable:
  - boot_active <= 0 on the edge after the pulse; sticky until rst.
  - A pulse in the same cycle as an IDLE grant does not affect that grant, since bypass uses the pre-edge boot_active.
  - Later CPU grants bypass.
  - Aux reads always access the ROM regardless of boot_active.
- Ack exclusivity: cpu_ack and aux_ack are never high in the same cycle. rdata registers of the non-winning requester are unchanged.
- Address wrap: addresses are used modulo 2^AW; no range check.

Optional Feature:
- Macro BOOTARB_ROUND_ROBIN_EN.
- Defined:
  - When both requests are present in IDLE, grant the requester that was not granted last.
  - The pointer updates on every grant; reset pointer = CPU, so aux wins the first tie.
  - A single requester is always granted.
- Undefined: fixed CPU priority as above; no pointer register is synthesized.

Test Plan:
- Reset, then cpu_req = 1 with cpu_addr = 14'h0000, ROM[0] = 8'hF3:
  - rom_rd_n low exactly 1 cycle (N+1) with rom_a = 0.
  - cpu_ack pulse at N+3 with cpu_rdata = 8'hF3.
- aux_req alone, aux_addr = 14'h3FFF, ROM[3FFF] = 8'h5A: aux_ack at N+3 with aux_rdata = 8'h5A; cpu_ack and cpu_rdata unchanged.
- cpu_req and aux_req both held for 4 grants:
  - Default: 4 cpu_acks, 0 aux_acks, acks 4 cycles apart.
  - With BOOTARB_ROUND_ROBIN_EN: order aux, cpu, aux, cpu.
- boot_disable pulse, then cpu_req at addr 14'h0010:
  - boot_active = 0.
  - rom_rd_n stays 1 throughout; cpu_ack at N+3 with cpu_rdata = 8'hFF.
  - A following aux read of 14'h0010 returns ROM contents.
- boot_disable pulsed in the same cycle a CPU grant is taken in IDLE: that read returns ROM data; the next CPU read returns 8'hFF.
- rst asserted during WAIT:
  - Next cycle: state IDLE, rom_rd_n = 1, no ack, rdata = 0, boot_active = 1.
  - A new request then completes normally in 3 cycles.
